rect_rasterizer: RTL and testbench
==================================

// Module: rect_rasterizer
// PURPOSE
//  Renderer-side write stage feeding the frame buffer write port (wr_en/wr_addr/wr_data) in the clk_renderer domain.
//  On each buffer swap it clears the back buffer to 0, then accepts a list of filled-rectangle commands over a
//  valid/ready handshake and writes each one in raster order, one pixel per enabled cycle.
//  Game logic drives commands; the 1-bit pixel value is rendered white/black at display.
// PARAMETERS
//  HOR_ACTIVE_PIXELS  640  visible width W; X_WIDTH = $clog2(W)
//  VER_ACTIVE_PIXELS  480  visible height H; Y_WIDTH = $clog2(H); PIXEL_ADDR_WIDTH = $clog2(W*H)
// PORTS
//  clk          in   1                 renderer clock
//  rst          in   1                 asynchronous, active-high reset
//  ce           in   1                 clock enable; 0 freezes all state
//  swap         in   1                 one-cycle pulse: buffers swapped, start a new frame
//  cmd_valid    in   1                 command present
//  cmd_ready    out  1                 command accepted when cmd_valid & cmd_ready & ce
//  cmd_x0/x1    in   X_WIDTH           inclusive column bounds
//  cmd_y0/y1    in   Y_WIDTH           inclusive row bounds
//  cmd_color    in   1                 pixel value to write
//  cmd_last     in   1                 final command of this frame
//  wr_en        out  1                 frame buffer write strobe
//  wr_addr      out  PIXEL_ADDR_WIDTH  y*W + x
//  wr_data      out  1                 pixel value
//  frame_ready  out  1                 level: frame fully drawn, waiting for swap
//  overrun      out  1                 one-cycle pulse: swap arrived before frame_ready
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready, wr_en, wr_addr, wr_data, frame_ready and overrun all 0. All outputs are registered.
//  - ce=0: every register holds. wr_en output = wr_en_q & ce. overrun is a registered one-cycle pulse; it is not
//    gated by ce.
//  - FSM: IDLE, CLEAR, WAIT_CMD, SETUP, DRAW, DONE.
//  - IDLE/DONE + swap -> CLEAR. frame_ready=1 only in DONE.
//  - CLEAR: writes wr_data=0 to addresses 0..W*H-1 in order, one per ce cycle (W*H cycles).
//    After address W*H-1 -> WAIT_CMD.
//  - WAIT_CMD: cmd_ready=1.
//    - On acceptance, latch the command with clipping: x1c=min(x1,W-1), y1c=min(y1,H-1).
//    - The command is empty if x0>x1c, y0>y1c, x0>=W or y0>=H.
//    - Non-empty -> SETUP. Empty with cmd_last -> DONE. Empty without cmd_last -> stay in WAIT_CMD.
//    - cmd_ready drops the cycle after acceptance.
//  - SETUP: one cycle; computes row_base = y0*W, then -> DRAW.
//    The first wr_en appears 2 enabled cycles after the accepting edge.
//  - DRAW: x runs x0..x1c inside y0..y1c, row by row; addr = row_base + x; at row end row_base += W.
//    wr_data = cmd_color. After pixel (x1c,y1c): cmd_last -> DONE, else -> WAIT_CMD.
//    Pixel count = (x1c-x0+1)*(y1c-y0+1), no gaps, no duplicates.
//  - Arithmetic: counters carry one extra bit so compares at W-1/H-1 do not wrap.
//    wr_addr never exceeds W*H-1.
//  - swap in CLEAR, WAIT_CMD, SETUP or DRAW:
//    - the current command is abandoned and overrun pulses for 1 cycle;
//    - -> CLEAR restarting at address 0; no write to the old address is issued after the swap edge.
//  - swap coincident with a cmd handshake: swap wins and the command is dropped.
//    The producer must re-send the list.
//  - Async rst mid-operation: outputs return to reset values immediately; then IDLE until the next swap.
//  - cmd inputs are ignored outside WAIT_CMD.
// TESTING
//  1. Reset, then swap -> exactly 307200 writes, data 0, addr 0..307199 in order, then cmd_ready=1.
//  2. Rect (10,20)-(12,21), color 1, last -> addrs 12810,12811,12812,13450,13451,13452, data 1, then frame_ready=1.
//  3. Rect (630,470)-(700,500) -> clipped to 100 writes; first addr 301430, last addr 307199; no addr >307199.
//  4. Rect x0=50,x1=40 with last -> zero writes, frame_ready=1 on the next cycle. Two back-to-back commands ->
//     writes are contiguous per command; cmd_ready=0 during SETUP/DRAW.
//  5. swap mid-DRAW of (0,0)-(639,479) -> overrun pulse 1 cycle, next wr_addr=0 with data 0 (CLEAR restarts).
//  6. ce toggled 1010 pattern during DRAW -> identical address sequence; wr_en never high while ce=0.

Source files
------------

// File: rtl/rect_rasterizer_if.sv
// Command stream and frame-buffer write port of the rectangle rasterizer.
// The producer drives commands through master; the rasterizer sits on slave.
interface rect_rasterizer_if #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
);
    localparam int X_WIDTH          = $clog2(HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH          = $clog2(VER_ACTIVE_PIXELS);
    localparam int PIXEL_ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [X_WIDTH-1:0]          cmd_x0;
    logic [X_WIDTH-1:0]          cmd_x1;
    logic [Y_WIDTH-1:0]          cmd_y0;
    logic [Y_WIDTH-1:0]          cmd_y1;
    logic                        cmd_color;
    logic                        cmd_last;
    logic                        wr_en;
    logic [PIXEL_ADDR_WIDTH-1:0] wr_addr;
    logic                        wr_data;

    modport master (
        output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_last,
        input  cmd_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_last,
        output cmd_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rect_rasterizer.sv
// Renderer write stage: clears the back buffer on swap, then fills clipped
// rectangles in raster order, one pixel per enabled cycle.
module rect_rasterizer #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 swap,
    rect_rasterizer_if.slave     bus,
    output logic                 frame_ready,
    output logic                 overrun
);
    localparam int W                = HOR_ACTIVE_PIXELS;
    localparam int H                = VER_ACTIVE_PIXELS;
    localparam int X_WIDTH          = $clog2(W);
    localparam int Y_WIDTH          = $clog2(H);
    localparam int PIXEL_ADDR_WIDTH = $clog2(W * H);

    localparam logic [X_WIDTH:0]          X_MAX     = (X_WIDTH + 1)'(W - 1);
    localparam logic [Y_WIDTH:0]          Y_MAX     = (Y_WIDTH + 1)'(H - 1);
    localparam logic [X_WIDTH:0]          X_LIM     = (X_WIDTH + 1)'(W);
    localparam logic [Y_WIDTH:0]          Y_LIM     = (Y_WIDTH + 1)'(H);
    localparam logic [PIXEL_ADDR_WIDTH-1:0] ADDR_LAST = PIXEL_ADDR_WIDTH'(W * H - 1);
    localparam logic [PIXEL_ADDR_WIDTH-1:0] ROW_STEP  = PIXEL_ADDR_WIDTH'(W);

    typedef enum logic [2:0] {IDLE, CLEAR, WAIT_CMD, SETUP, DRAW, DONE} state_t;

    state_t                      state_q, state_d;
    logic [X_WIDTH:0]            x_q, x_d, x0_q, x0_d, x1c_q, x1c_d;
    logic [Y_WIDTH:0]            y_q, y_d, y1c_q, y1c_d;
    logic                        color_q, color_d, last_q, last_d;
    logic [PIXEL_ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic                        wr_en_q, wr_en_d, wr_data_q, wr_data_d;
    logic [PIXEL_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                        cmd_ready_q, cmd_ready_d;
    logic                        frame_ready_q, frame_ready_d;
    logic                        overrun_q, overrun_d;

    // Incoming command widened by one bit so the bound compares never wrap.
    logic [X_WIDTH:0] cx0, cx1, cx1c;
    logic [Y_WIDTH:0] cy0, cy1, cy1c;
    logic             cmd_empty, busy;

    assign cx0       = {1'b0, bus.cmd_x0};
    assign cx1       = {1'b0, bus.cmd_x1};
    assign cy0       = {1'b0, bus.cmd_y0};
    assign cy1       = {1'b0, bus.cmd_y1};
    assign cx1c      = (cx1 > X_MAX) ? X_MAX : cx1;
    assign cy1c      = (cy1 > Y_MAX) ? Y_MAX : cy1;
    assign cmd_empty = (cx0 > cx1c) | (cy0 > cy1c) | (cx0 >= X_LIM) | (cy0 >= Y_LIM);
    assign busy      = (state_q == CLEAR) | (state_q == WAIT_CMD) |
                       (state_q == SETUP) | (state_q == DRAW);
    assign overrun_d = ce & swap & busy;

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        x0_d          = x0_q;
        x1c_d         = x1c_q;
        y1c_d         = y1c_q;
        color_d       = color_q;
        last_d        = last_q;
        row_base_d    = row_base_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        cmd_ready_d   = 1'b0;
        frame_ready_d = 1'b0;

        if (swap) begin
            // Swap pre-empts everything, including a coincident handshake.
            state_d   = CLEAR;
            wr_en_d   = 1'b1;
            wr_addr_d = '0;
            wr_data_d = 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (wr_addr_q == ADDR_LAST) begin
                        state_d     = WAIT_CMD;
                        cmd_ready_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                        wr_data_d = 1'b0;
                    end
                end
                WAIT_CMD: begin
                    cmd_ready_d = 1'b1;
                    if (bus.cmd_valid) begin
                        x_d     = cx0;
                        x0_d    = cx0;
                        x1c_d   = cx1c;
                        y_d     = cy0;
                        y1c_d   = cy1c;
                        color_d = bus.cmd_color;
                        last_d  = bus.cmd_last;
                        if (!cmd_empty) begin
                            state_d     = SETUP;
                            cmd_ready_d = 1'b0;
                        end else if (bus.cmd_last) begin
                            state_d       = DONE;
                            cmd_ready_d   = 1'b0;
                            frame_ready_d = 1'b1;
                        end
                    end
                end
                SETUP: begin
                    row_base_d = PIXEL_ADDR_WIDTH'(y_q) * ROW_STEP;
                    state_d    = DRAW;
                end
                DRAW: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = row_base_q + PIXEL_ADDR_WIDTH'(x_q);
                    wr_data_d = color_q;
                    if (x_q != x1c_q) begin
                        x_d = x_q + 1'b1;
                    end else if (y_q != y1c_q) begin
                        x_d        = x0_q;
                        y_d        = y_q + 1'b1;
                        row_base_d = row_base_q + ROW_STEP;
                    end else if (last_q) begin
                        state_d       = DONE;
                        frame_ready_d = 1'b1;
                    end else begin
                        state_d     = WAIT_CMD;
                        cmd_ready_d = 1'b1;
                    end
                end
                DONE:    frame_ready_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            x0_q          <= '0;
            x1c_q         <= '0;
            y1c_q         <= '0;
            color_q       <= 1'b0;
            last_q        <= 1'b0;
            row_base_q    <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 1'b0;
            cmd_ready_q   <= 1'b0;
            frame_ready_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            // Overrun always clears after one cycle, independent of ce.
            overrun_q <= overrun_d;
            if (ce) begin
                state_q       <= state_d;
                x_q           <= x_d;
                y_q           <= y_d;
                x0_q          <= x0_d;
                x1c_q         <= x1c_d;
                y1c_q         <= y1c_d;
                color_q       <= color_d;
                last_q        <= last_d;
                row_base_q    <= row_base_d;
                wr_en_q       <= wr_en_d;
                wr_addr_q     <= wr_addr_d;
                wr_data_q     <= wr_data_d;
                cmd_ready_q   <= cmd_ready_d;
                frame_ready_q <= frame_ready_d;
            end
        end
    end

    assign bus.wr_en     = wr_en_q & ce;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign frame_ready   = frame_ready_q;
    assign overrun       = overrun_q;
endmodule

// File: tb/tb_rect_rasterizer.sv
// Bench for rect_rasterizer on a reduced 40x30 frame: an expected-write queue
// built from the rectangle rules is checked against every observed write.
module tb_rect_rasterizer;
    localparam int W  = 40;
    localparam int H  = 30;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce = 1'b1;
    logic swap = 1'b0;
    logic frame_ready, overrun;

    rect_rasterizer_if #(.HOR_ACTIVE_PIXELS(W), .VER_ACTIVE_PIXELS(H)) bus ();

    rect_rasterizer #(.HOR_ACTIVE_PIXELS(W), .VER_ACTIVE_PIXELS(H)) dut (
        .clk(clk), .rst(rst), .ce(ce), .swap(swap), .bus(bus),
        .frame_ready(frame_ready), .overrun(overrun)
    );

    typedef struct { int addr; bit data; } wr_t;

    wr_t exp_q[$];
    int  obs_addr[$];
    bit  obs_data[$];
    int  obs_cyc[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    bit  ce_tog = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model: a clear is every address in order with data 0; a rectangle is
    // clipped to the frame and expanded row by row.
    function automatic void push_clear();
        for (int a = 0; a < W * H; a++) exp_q.push_back('{a, 1'b0});
    endfunction

    function automatic void model_rect(input int x0, x1, y0, y1, input bit c);
        int xe, ye;
        xe = (x1 < W - 1) ? x1 : W - 1;
        ye = (y1 < H - 1) ? y1 : H - 1;
        for (int y = y0; y <= ye; y++)
            for (int x = x0; x <= xe; x++)
                exp_q.push_back('{y * W + x, c});
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (!ce) check("wr_en_while_ce_low", int'(bus.wr_en), 0);
            if (bus.wr_en) begin
                wr_t e;
                obs_addr.push_back(int'(bus.wr_addr));
                obs_data.push_back(bus.wr_data);
                obs_cyc.push_back(cyc);
                check("wr_addr_in_range", int'(bus.wr_addr < W * H), 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %0d expected no write", bus.wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", int'(bus.wr_addr), e.addr);
                    check("wr_data", int'(bus.wr_data), int'(e.data));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce_tog) ce = ~ce;
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
    endtask

    task automatic send_cmd(input int x0, x1, y0, y1, input bit c, input bit l);
        bit acc;
        acc = 1'b0;
        bus.cmd_x0    = x0[XW-1:0];
        bus.cmd_x1    = x1[XW-1:0];
        bus.cmd_y0    = y0[YW-1:0];
        bus.cmd_y1    = y1[YW-1:0];
        bus.cmd_color = c;
        bus.cmd_last  = l;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5000 && !acc; i++) begin
            if (bus.cmd_ready && ce) begin
                model_rect(x0, x1, y0, y1, c);
                acc = 1'b1;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accepted", int'(acc), 1);
    endtask

    task automatic do_swap(input bit exp_ovr);
        swap = 1'b1;
        tick();
        swap = 1'b0;
        exp_q.delete();
        clear_obs();
        push_clear();
        @(negedge clk);
        check("overrun_pulse", int'(overrun), int'(exp_ovr));
        @(negedge clk);
        check("overrun_one_cycle", int'(overrun), 0);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int t2[6] = '{810, 811, 812, 850, 851, 852};
        int t4[5] = '{0, 1, 2, 45, 46};
        int t6[6] = '{83, 84, 85, 123, 124, 125};
        bus.cmd_valid = 1'b0;
        bus.cmd_x0 = '0; bus.cmd_x1 = '0; bus.cmd_y0 = '0; bus.cmd_y1 = '0;
        bus.cmd_color = 1'b0; bus.cmd_last = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", int'(bus.cmd_ready), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);
        check("rst_frame_ready", int'(frame_ready), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("idle_no_write", int'(bus.wr_en), 0);
        check("idle_cmd_ready", int'(bus.cmd_ready), 0);

        // Full clear, then ready for commands
        do_swap(1'b0);
        drain("clear_drain");
        @(negedge clk);
        check("clear_count", obs_addr.size(), W * H);
        check("clear_first", obs_addr[0], 0);
        check("clear_last", obs_addr[W * H - 1], W * H - 1);
        check("clear_cmd_ready", int'(bus.cmd_ready), 1);

        // Small rect, last command
        clear_obs();
        send_cmd(10, 12, 20, 21, 1'b1, 1'b1);
        drain("rect_drain");
        @(negedge clk);
        check("rect_count", obs_addr.size(), 6);
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) check("rect_addr_lit", obs_addr[i], t2[i]);
        if (obs_cyc.size() == 6) check("rect_no_gaps", obs_cyc[5] - obs_cyc[0], 5);
        check("rect_frame_ready", int'(frame_ready), 1);
        check("rect_cmd_ready_done", int'(bus.cmd_ready), 0);

        // Clipped rect at bottom-right corner
        do_swap(1'b0);
        drain("clear2_drain");
        clear_obs();
        send_cmd(35, 50, 27, 31, 1'b1, 1'b0);
        drain("clip_drain");
        @(negedge clk);
        check("clip_count", obs_addr.size(), 15);
        if (obs_addr.size() == 15) begin
            check("clip_first", obs_addr[0], 1115);
            check("clip_last", obs_addr[14], 1199);
        end
        check("clip_cmd_ready", int'(bus.cmd_ready), 1);

        // Back-to-back commands, then empty commands
        clear_obs();
        send_cmd(0, 2, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("setup_cmd_ready", int'(bus.cmd_ready), 0);
        send_cmd(5, 6, 1, 1, 1'b0, 1'b0);
        drain("b2b_drain");
        @(negedge clk);
        check("b2b_count", obs_addr.size(), 5);
        for (int i = 0; i < 5 && i < obs_addr.size(); i++) check("b2b_addr_lit", obs_addr[i], t4[i]);
        if (obs_cyc.size() == 5) check("b2b_contiguous", obs_cyc[2] - obs_cyc[0], 2);
        if (obs_data.size() == 5) check("b2b_color0", int'(obs_data[3]), 0);
        send_cmd(45, 50, 0, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("empty_stays_ready", int'(bus.cmd_ready), 1);
        send_cmd(20, 15, 0, 0, 1'b1, 1'b1);
        @(negedge clk);
        check("empty_last_frame_ready", int'(frame_ready), 1);
        repeat (3) tick();
        check("empty_no_writes", obs_addr.size(), 5);

        // Swap mid-draw
        do_swap(1'b0);
        drain("clear3_drain");
        clear_obs();
        send_cmd(0, 63, 0, 31, 1'b1, 1'b1);
        for (int i = 0; i < 500 && obs_addr.size() < 50; i++) tick();
        check("draw_progress", int'(obs_addr.size() >= 50), 1);
        do_swap(1'b1);
        drain("restart_drain");
        @(negedge clk);
        check("restart_count", obs_addr.size(), W * H);
        if (obs_addr.size() > 0) begin
            check("restart_addr0", obs_addr[0], 0);
            check("restart_data0", int'(obs_data[0]), 0);
        end

        // ce toggling during draw
        clear_obs();
        send_cmd(3, 5, 2, 3, 1'b1, 1'b1);
        ce_tog = 1'b1;
        drain("ce_drain");
        ce_tog = 1'b0;
        ce = 1'b1;
        @(negedge clk);
        check("ce_count", obs_addr.size(), 6);
        for (int i = 0; i < 6 && i < obs_addr.size(); i++) check("ce_addr_lit", obs_addr[i], t6[i]);
        if (obs_cyc.size() == 6) check("ce_half_rate", obs_cyc[5] - obs_cyc[0], 10);
        check("ce_frame_ready", int'(frame_ready), 1);

        // Async reset in the middle of a clear
        do_swap(1'b0);
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("arst_wr_en", int'(bus.wr_en), 0);
        check("arst_wr_addr", int'(bus.wr_addr), 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("arst_idle_wr_en", int'(bus.wr_en), 0);
        check("arst_idle_cmd_ready", int'(bus.cmd_ready), 0);
        check("arst_idle_frame_ready", int'(frame_ready), 0);

        check("model_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
